// File: rtl/timer_core_prescaled.sv
// timer_core_prescaled: prescaled down-counting timer with one-shot/auto-reload, pause/resume and sticky irq
module timer_core_prescaled #(
  parameter int WIDTH = 32,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             resume,
  input  logic             irq_clr,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_value,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             expired,
  output logic             irq
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, reload_q, reload_d;
  logic [PRE_W-1:0] pre_q, pre_d, prescale_q, prescale_d;
  logic             mode_q, mode_d, expired_q, expired_d, irq_q, irq_d, tick;
  // next state: start beats stop beats resume; a running tick is skipped on any control edge
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pre_d      = pre_q;
    reload_d   = reload_q;
    prescale_d = prescale_q;
    mode_d     = mode_q;
    expired_d  = 1'b0;
    tick       = 1'b0;
    if (start) begin
      count_d    = load_value;
      pre_d      = '0;
      reload_d   = load_value;
      prescale_d = prescale;
      mode_d     = auto_reload;
      expired_d  = (load_value == '0);
      state_d    = (load_value == '0) ? IDLE : RUN;
    end else if (state_q == RUN && stop) begin
      state_d = PAUSED;
    end else if (state_q == PAUSED && resume) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      tick  = (pre_q == prescale_q);
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
      if (tick && count_q > WIDTH'(1)) begin
        count_d = count_q - WIDTH'(1);
      end else if (tick) begin
        expired_d = 1'b1;
        count_d   = mode_q ? reload_q : '0;
        state_d   = mode_q ? RUN : IDLE;
      end
    end
    irq_d = expired_d | (irq_q & ~irq_clr);
  end
  // state and datapath registers, cleared asynchronously so a reset aborts any pending expiry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      pre_q      <= '0;
      reload_q   <= '0;
      prescale_q <= '0;
      mode_q     <= 1'b0;
      expired_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pre_q      <= pre_d;
      reload_q   <= reload_d;
      prescale_q <= prescale_d;
      mode_q     <= mode_d;
      expired_q  <= expired_d;
      irq_q      <= irq_d;
    end
  end
  assign count   = count_q;
  assign running = (state_q == RUN);
  assign expired = expired_q;
  assign irq     = irq_q;
endmodule

// File: tb/tb_timer_core_prescaled.sv
// tb_timer_core_prescaled: random and directed stimulus scored against an elapsed-time reference model
module tb_timer_core_prescaled;
  localparam int W = 8;
  localparam int PW = 3;
  logic          clk = 1'b0, reset_n = 1'b0;
  logic          start = 0, stop = 0, resume = 0, irq_clr = 0, auto_reload = 0;
  logic [W-1:0]  load_value = '0, count;
  logic [PW-1:0] prescale = '0;
  logic          running, expired, irq;

  timer_core_prescaled #(.WIDTH(W), .PRE_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .resume(resume),
    .irq_clr(irq_clr), .auto_reload(auto_reload), .load_value(load_value),
    .prescale(prescale), .count(count), .running(running), .expired(expired), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {logic [W-1:0] c; logic r; logic e; logic i;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;

  // reference: run time is tracked as elapsed running cycles since the last (re)load
  int     m_st = 0;
  longint el = 0;
  int     m_n = 0, m_p = 0, m_cnt = 0;
  bit     m_ar = 0, m_exp = 0, m_irq = 0;

  task automatic check(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_step();
    exp_t e;
    if (!reset_n) begin
      m_st = 0; el = 0; m_n = 0; m_p = 0; m_cnt = 0; m_ar = 0; m_exp = 0; m_irq = 0;
    end else begin
      m_exp = 0;
      if (start) begin
        m_n = int'(load_value); m_p = int'(prescale); m_ar = auto_reload; el = 0;
        if (m_n == 0) begin m_exp = 1; m_st = 0; m_cnt = 0; end
        else m_st = 1;
      end else if (m_st == 1 && stop) m_st = 2;
      else if (m_st == 2 && resume) m_st = 1;
      else if (m_st == 1) begin
        el++;
        if (el == longint'(m_n) * (m_p + 1)) begin
          m_exp = 1;
          el = 0;
          if (!m_ar) begin m_st = 0; m_cnt = 0; end
        end
      end
      m_irq = m_exp | (m_irq & !irq_clr);
    end
    e.c = (m_st == 0) ? W'(m_cnt) : W'(longint'(m_n) - el / (m_p + 1));
    e.r = (m_st == 1);
    e.e = m_exp;
    e.i = m_irq;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("count", count, e.c);
      check("running", running, e.r);
      check("expired", expired, e.e);
      check("irq", irq, e.i);
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_start(input bit ar, input int ld, input int pr);
    start = 1; auto_reload = ar; load_value = W'(ld); prescale = PW'(pr);
    step();
    start = 0;
  endtask

  task automatic pulse(input int which);
    if (which == 0) stop = 1;
    else if (which == 1) resume = 1;
    else irq_clr = 1;
    step();
    stop = 0; resume = 0; irq_clr = 0;
  endtask

  initial begin
    step_n(2);
    reset_n = 1;
    step();
    pulse_start(0, 12, 0); step_n(14);
    pulse_start(0, 3, 3); step_n(13); pulse(2); step_n(2);
    pulse_start(0, 5, 0); step_n(3); pulse(0); step_n(5); pulse(1); step_n(4);
    pulse_start(1, 4, 1); step_n(24);
    step_n(5); pulse_start(1, 4, 1); step_n(10);
    pulse_start(1, 0, 1); step_n(3);
    start = 1; stop = 1; load_value = 6; prescale = 0; step(); start = 0; stop = 0; step_n(3);
    pulse_start(0, 3, 0); step_n(2); pulse(2); step_n(2);
    pulse_start(0, 4, 1); step_n(1); pulse(0); pulse(1); step_n(10);
    pulse(0); pulse(1); pulse(0);
    pulse_start(0, 255, 0); step_n(258);
    pulse_start(0, 10, 0); step_n(4);
    @(negedge clk); #1;
    reset_n = 0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_running", running, 0);
    check("async_rst_expired", expired, 0);
    check("async_rst_irq", irq, 0);
    step_n(2);
    @(negedge clk); #1;
    reset_n = 1;
    step_n(14);
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 19) == 0);
      stop = ($urandom_range(0, 14) == 0);
      resume = ($urandom_range(0, 7) == 0);
      irq_clr = ($urandom_range(0, 9) == 0);
      auto_reload = $urandom_range(0, 1);
      load_value = W'($urandom_range(0, 12));
      prescale = PW'($urandom_range(0, 3));
      step();
    end
    start = 0; stop = 0; resume = 0; irq_clr = 0;
    step_n(3);
    @(negedge clk); #1;
    check("queue_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
